rps_round_ctrl: RTL

Round controller for the rock-paper-scissors game. Consumes command/move bytes delivered by the SPI receiver (SIG plus done) and collects one move from each of two players in either order. It then judges the round, keeps per-player scores and drives the 3-bit result LEDs. Sits between the SPI receiver and the LED pins, replacing direct byte-to-LED decoding with a sequenced round/match flow.

---
 rtl/rps_pkg.sv | 36 +++
 rtl/rps_round_ctrl_if.sv | 8 +
 rtl/rps_judge.sv | 22 ++
 rtl/rps_round_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared types and encodings for the rock-paper-scissors round controller.
package rps_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        ROCK     = 2'b01,
        PAPER    = 2'b10,
        SCISSORS = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        COLLECT    = 2'b00,
        JUDGE      = 2'b01,
        SHOW       = 2'b10,
        MATCH_OVER = 2'b11
    } state_t;

    // SIG[7:6] opcodes
    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_NEXT  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_TIE  = 2'b11;

    localparam logic [2:0] LED_NONE = 3'b000;
    localparam logic [2:0] LED_P1   = 3'b001;
    localparam logic [2:0] LED_P2   = 3'b010;
    localparam logic [2:0] LED_TIE  = 3'b100;
    localparam logic [2:0] LED_M_P1 = 3'b101;
    localparam logic [2:0] LED_M_P2 = 3'b110;

endpackage

// File: rtl/rps_round_ctrl_if.sv
// Byte-delivery link from the SPI receiver into the round controller.
interface rps_round_ctrl_if;
    logic [7:0] SIG;
    logic       done;

    modport master (output SIG, output done);
    modport slave  (input  SIG, input  done);
endinterface

// File: rtl/rps_judge.sv
// Combinational round judge: compares two valid moves and returns the winner code.
module rps_judge
    import rps_pkg::*;
(
    input  move_t      p1,
    input  move_t      p2,
    output logic [1:0] win
);

    always_comb begin
        win = W_TIE;
        if (p1 != p2) begin
            case ({p1, p2})
                {ROCK, SCISSORS},
                {SCISSORS, PAPER},
                {PAPER, ROCK}:      win = W_P1;
                default:            win = W_P2;
            endcase
        end
    end

endmodule

// File: rtl/rps_round_ctrl.sv
// Round/match controller: collects both moves, judges, keeps scores, drives LEDs.
// Optional match termination is compiled in with `define RPS_MATCH_EN.
module rps_round_ctrl
    import rps_pkg::*;
#(
    parameter int SCORE_W      = 4,
    parameter int MATCH_POINTS = 3
) (
    input  logic               sck,
    input  logic               reset,
    rps_round_ctrl_if.slave    rx,
    output logic [2:0]         LED,
    output logic [1:0]         winner,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               busy
);

    localparam logic [SCORE_W-1:0] SMAX = '1;
    localparam logic [SCORE_W-1:0] ONE  = SCORE_W'(1);

    if (MATCH_POINTS < 1 || MATCH_POINTS > (2**SCORE_W) - 1) begin : g_bad_match_points
        $error("MATCH_POINTS out of range for SCORE_W");
    end

`ifdef RPS_MATCH_EN
    localparam logic [SCORE_W-1:0] MP = SCORE_W'(MATCH_POINTS);
`endif

    state_t             state_q, state_n;
    move_t              p1_mv_q, p1_mv_n, p2_mv_q, p2_mv_n;
    logic               have_p1_q, have_p1_n, have_p2_q, have_p2_n;
    logic               done_q;
    logic [2:0]         led_q, led_n;
    logic [1:0]         win_q, win_n;
    logic [SCORE_W-1:0] s1_q, s1_n, s2_q, s2_n;

    logic               ev;
    logic [1:0]         op;
    logic               pl;
    move_t              mv;
    logic [1:0]         jwin;
    logic               unused_sig_bits;

    assign ev = rx.done & ~done_q;
    assign op = rx.SIG[7:6];
    assign pl = rx.SIG[5];
    assign mv = move_t'(rx.SIG[1:0]);
    assign unused_sig_bits = ^rx.SIG[4:2];

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SMAX) ? s : s + ONE;
    endfunction

    rps_judge u_judge (
        .p1  (p1_mv_q),
        .p2  (p2_mv_q),
        .win (jwin)
    );

    always_ff @(posedge sck or posedge reset) begin
        if (reset) begin
            state_q   <= COLLECT;
            p1_mv_q   <= NONE;
            p2_mv_q   <= NONE;
            have_p1_q <= 1'b0;
            have_p2_q <= 1'b0;
            done_q    <= 1'b0;
            led_q     <= LED_NONE;
            win_q     <= W_NONE;
            s1_q      <= '0;
            s2_q      <= '0;
        end else begin
            state_q   <= state_n;
            p1_mv_q   <= p1_mv_n;
            p2_mv_q   <= p2_mv_n;
            have_p1_q <= have_p1_n;
            have_p2_q <= have_p2_n;
            done_q    <= rx.done;
            led_q     <= led_n;
            win_q     <= win_n;
            s1_q      <= s1_n;
            s2_q      <= s2_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        p1_mv_n   = p1_mv_q;
        p2_mv_n   = p2_mv_q;
        have_p1_n = have_p1_q;
        have_p2_n = have_p2_q;
        led_n     = led_q;
        win_n     = win_q;
        s1_n      = s1_q;
        s2_n      = s2_q;

        // CLEAR overrides whatever the FSM is doing, including JUDGE
        if (ev && op == OP_CLEAR) begin
            state_n   = COLLECT;
            p1_mv_n   = NONE;
            p2_mv_n   = NONE;
            have_p1_n = 1'b0;
            have_p2_n = 1'b0;
            led_n     = LED_NONE;
            win_n     = W_NONE;
            s1_n      = '0;
            s2_n      = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (ev && op == OP_MOVE && mv != NONE) begin
                        if (!pl && !have_p1_q) begin
                            p1_mv_n   = mv;
                            have_p1_n = 1'b1;
                            if (have_p2_q) state_n = JUDGE;
                        end else if (pl && !have_p2_q) begin
                            p2_mv_n   = mv;
                            have_p2_n = 1'b1;
                            if (have_p1_q) state_n = JUDGE;
                        end
                    end
                end
                JUDGE: begin
                    win_n   = jwin;
                    state_n = SHOW;
                    case (jwin)
                        W_P1: begin
                            led_n = LED_P1;
                            s1_n  = sat_inc(s1_q);
                        end
                        W_P2: begin
                            led_n = LED_P2;
                            s2_n  = sat_inc(s2_q);
                        end
                        default: led_n = LED_TIE;
                    endcase
`ifdef RPS_MATCH_EN
                    if (jwin == W_P1 && s1_n == MP && s1_q != MP) begin
                        state_n = MATCH_OVER;
                        led_n   = LED_M_P1;
                    end else if (jwin == W_P2 && s2_n == MP && s2_q != MP) begin
                        state_n = MATCH_OVER;
                        led_n   = LED_M_P2;
                    end
`endif
                end
                SHOW: begin
                    if (ev && op == OP_NEXT) begin
                        state_n   = COLLECT;
                        p1_mv_n   = NONE;
                        p2_mv_n   = NONE;
                        have_p1_n = 1'b0;
                        have_p2_n = 1'b0;
                        led_n     = LED_NONE;
                        win_n     = W_NONE;
                    end
                end
`ifdef RPS_MATCH_EN
                MATCH_OVER: ;
`endif
                default: state_n = COLLECT;
            endcase
        end
    end

    assign LED      = led_q;
    assign winner   = win_q;
    assign p1_score = s1_q;
    assign p2_score = s2_q;
    assign busy     = (state_q == COLLECT) & (have_p1_q | have_p2_q);

endmodule
